// File: rtl/alu_arbiter_if.sv
// Requester / ALU / response bundle for alu_arbiter.
// slave  : the arbiter side (drives grants, alu issue, responses, err)
// master : the environment side (requesters and the alu)
interface alu_arbiter_if #(
   parameter int NREQ   = 4,
   parameter int DATA_W = 32,
   parameter int OPC_W  = 5
);
   logic [NREQ-1:0]        req_vld;
   logic [NREQ-1:0]        req_rdy;
   logic [NREQ*OPC_W-1:0]  req_opcode;
   logic [NREQ*DATA_W-1:0] req_op0;
   logic [NREQ*DATA_W-1:0] req_op1;
   logic                   alu_vld;
   logic [OPC_W-1:0]       alu_opcode;
   logic [DATA_W-1:0]      alu_op0;
   logic [DATA_W-1:0]      alu_op1;
   logic                   alu_result_vld;
   logic [DATA_W-1:0]      alu_result;
   logic [NREQ-1:0]        rsp_vld;
   logic [DATA_W-1:0]      rsp_result;
   logic                   err;

   modport slave (
      input  req_vld, req_opcode, req_op0, req_op1, alu_result_vld, alu_result,
      output req_rdy, alu_vld, alu_opcode, alu_op0, alu_op1, rsp_vld, rsp_result, err
   );

   modport master (
      output req_vld, req_opcode, req_op0, req_op1, alu_result_vld, alu_result,
      input  req_rdy, alu_vld, alu_opcode, alu_op0, alu_op1, rsp_vld, rsp_result, err
   );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one pipelined alu among NREQ requesters.
// A tag pipeline of ALU_LAT {valid, index} stages shadows the alu so each
// result is routed back to the requester that issued it. A result_vld that
// disagrees with the tag pipeline sets a sticky error.
module alu_arbiter #(
   parameter int NREQ    = 4,
   parameter int DATA_W  = 32,
   parameter int OPC_W   = 5,
   parameter int ALU_LAT = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          ce,
   alu_arbiter_if.slave  bus
);
   localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
   typedef logic [IDX_W-1:0] idx_t;

   idx_t                           last_grant_q, last_grant_d;
   logic                           alu_vld_q, alu_vld_d;
   logic [OPC_W-1:0]               alu_opcode_q, alu_opcode_d;
   logic [DATA_W-1:0]              alu_op0_q, alu_op0_d;
   logic [DATA_W-1:0]              alu_op1_q, alu_op1_d;
   idx_t                           issue_idx_q, issue_idx_d;
   logic [ALU_LAT-1:0]             tag_vld_q, tag_vld_d;
   logic [ALU_LAT-1:0][IDX_W-1:0]  tag_idx_q, tag_idx_d;
   logic [NREQ-1:0]                rsp_vld_q, rsp_vld_d;
   logic [DATA_W-1:0]              rsp_result_q, rsp_result_d;
   logic                           err_q, err_d;

   logic                           accept;
   idx_t                           grant_idx;
   idx_t                           cand;
   logic [NREQ-1:0]                req_rdy_c;

   // Round-robin search starting just after the last granted requester.
   always_comb begin
      accept    = 1'b0;
      grant_idx = '0;
      cand      = '0;
      req_rdy_c = '0;
      if (ce && rst) begin
         for (int k = 1; k <= NREQ; k++) begin
            cand = idx_t'((int'(last_grant_q) + k) % NREQ);
            if (!accept && bus.req_vld[cand]) begin
               accept    = 1'b1;
               grant_idx = cand;
            end
         end
      end
      if (accept) req_rdy_c[grant_idx] = 1'b1;
   end

   // Next state: issue, tag shift, return routing and error detection; all frozen when ce=0.
   always_comb begin
      last_grant_d = last_grant_q;
      alu_vld_d    = alu_vld_q;
      alu_opcode_d = alu_opcode_q;
      alu_op0_d    = alu_op0_q;
      alu_op1_d    = alu_op1_q;
      issue_idx_d  = issue_idx_q;
      tag_vld_d    = tag_vld_q;
      tag_idx_d    = tag_idx_q;
      rsp_vld_d    = rsp_vld_q;
      rsp_result_d = rsp_result_q;
      err_d        = err_q;
      if (ce) begin
         alu_vld_d = accept;
         if (accept) begin
            last_grant_d = grant_idx;
            issue_idx_d  = grant_idx;
            alu_opcode_d = bus.req_opcode[grant_idx*OPC_W +: OPC_W];
            alu_op0_d    = bus.req_op0[grant_idx*DATA_W +: DATA_W];
            alu_op1_d    = bus.req_op1[grant_idx*DATA_W +: DATA_W];
         end
         tag_vld_d[0] = alu_vld_q;
         tag_idx_d[0] = issue_idx_q;
         for (int s = 1; s < ALU_LAT; s++) begin
            tag_vld_d[s] = tag_vld_q[s-1];
            tag_idx_d[s] = tag_idx_q[s-1];
         end
         rsp_vld_d = '0;
         if (bus.alu_result_vld != tag_vld_q[ALU_LAT-1]) begin
            err_d = 1'b1;
         end else if (bus.alu_result_vld) begin
            rsp_vld_d[tag_idx_q[ALU_LAT-1]] = 1'b1;
            rsp_result_d                    = bus.alu_result;
         end
      end
   end

   // State register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         last_grant_q <= idx_t'(NREQ - 1);
         alu_vld_q    <= 1'b0;
         alu_opcode_q <= '0;
         alu_op0_q    <= '0;
         alu_op1_q    <= '0;
         issue_idx_q  <= '0;
         tag_vld_q    <= '0;
         tag_idx_q    <= '0;
         rsp_vld_q    <= '0;
         rsp_result_q <= '0;
         err_q        <= 1'b0;
      end else begin
         last_grant_q <= last_grant_d;
         alu_vld_q    <= alu_vld_d;
         alu_opcode_q <= alu_opcode_d;
         alu_op0_q    <= alu_op0_d;
         alu_op1_q    <= alu_op1_d;
         issue_idx_q  <= issue_idx_d;
         tag_vld_q    <= tag_vld_d;
         tag_idx_q    <= tag_idx_d;
         rsp_vld_q    <= rsp_vld_d;
         rsp_result_q <= rsp_result_d;
         err_q        <= err_d;
      end
   end

   // A pending response pulse is held through ce=0 and shown once ce returns.
   assign bus.req_rdy    = req_rdy_c;
   assign bus.alu_vld    = alu_vld_q;
   assign bus.alu_opcode = alu_opcode_q;
   assign bus.alu_op0    = alu_op0_q;
   assign bus.alu_op1    = alu_op1_q;
   assign bus.rsp_vld    = ce ? rsp_vld_q : '0;
   assign bus.rsp_result = rsp_result_q;
   assign bus.err        = err_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small ce-gated alu model (result = op0 + op1).
module tb_alu_arbiter;
   localparam int NREQ = 4;
   localparam int DW   = 32;
   localparam int OW   = 5;
   localparam int LAT  = 2;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic ce  = 1'b1;
   logic inj = 1'b0;
   int   nchk  = 0;
   int   npass = 0;

   always #5 clk = ~clk;

   alu_arbiter_if #(.NREQ(NREQ), .DATA_W(DW), .OPC_W(OW)) bus ();

   alu_arbiter #(.NREQ(NREQ), .DATA_W(DW), .OPC_W(OW), .ALU_LAT(LAT)) dut (
      .clk (clk),
      .rst (rst),
      .ce  (ce),
      .bus (bus.slave)
   );

   // alu model: LAT ce-gated stages, reset shared with the arbiter
   logic [LAT-1:0]         mv;
   logic [LAT-1:0][DW-1:0] mr;
   always @(posedge clk) begin
      if (!rst) begin
         mv <= '0;
         mr <= '0;
      end else if (ce) begin
         mv[0] <= bus.alu_vld;
         mr[0] <= bus.alu_op0 + bus.alu_op1;
         for (int s = 1; s < LAT; s++) begin
            mv[s] <= mv[s-1];
            mr[s] <= mr[s-1];
         end
      end
   end
   assign bus.alu_result_vld = mv[LAT-1] | inj;
   assign bus.alu_result     = mr[LAT-1];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nchk++;
      assert (obs === exp) npass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [OW-1:0] opc, input logic [DW-1:0] a, input logic [DW-1:0] b);
      bus.req_opcode[i*OW +: OW] = opc;
      bus.req_op0[i*DW +: DW]    = a;
      bus.req_op1[i*DW +: DW]    = b;
   endtask

   initial begin
      bus.req_vld    = '0;
      bus.req_opcode = '0;
      bus.req_op0    = '0;
      bus.req_op1    = '0;

      // reset state; requests present but no grant while rst=0
      rst = 1'b0;
      bus.req_vld = 4'b1111;
      cyc(); cyc(); #1;
      chk("rst_rdy",    64'(bus.req_rdy),    64'(0));
      chk("rst_alu_vld",64'(bus.alu_vld),    64'(0));
      chk("rst_op0",    64'(bus.alu_op0),    64'(0));
      chk("rst_rsp_vld",64'(bus.rsp_vld),    64'(0));
      chk("rst_rsp_res",64'(bus.rsp_result), 64'(0));
      chk("rst_err",    64'(bus.err),        64'(0));
      bus.req_vld = '0;
      cyc();
      rst = 1'b1;

      // single op: requester 1, opcode 3, 5 + 7
      set_req(1, 5'd3, 32'd5, 32'd7);
      bus.req_vld = 4'b0010;
      #1; chk("t1_rdy", 64'(bus.req_rdy), 64'(4'b0010));
      cyc(); bus.req_vld = '0; #1;
      chk("t1_alu_vld", 64'(bus.alu_vld),    64'(1));
      chk("t1_opc",     64'(bus.alu_opcode), 64'(3));
      chk("t1_op0",     64'(bus.alu_op0),    64'(5));
      chk("t1_op1",     64'(bus.alu_op1),    64'(7));
      cyc(); #1;
      chk("t1_alu_vld_off", 64'(bus.alu_vld), 64'(0));
      cyc(); #1;
      chk("t1_res_vld", 64'(bus.alu_result_vld), 64'(1));
      chk("t1_res",     64'(bus.alu_result),     64'(12));
      chk("t1_rsp_early", 64'(bus.rsp_vld),      64'(0));
      cyc(); #1;
      chk("t1_rsp_vld", 64'(bus.rsp_vld),    64'(4'b0010));
      chk("t1_rsp_res", 64'(bus.rsp_result), 64'(12));
      cyc(); #1;
      chk("t1_rsp_pulse", 64'(bus.rsp_vld),    64'(0));
      chk("t1_rsp_hold",  64'(bus.rsp_result), 64'(12));
      chk("t1_err",       64'(bus.err),        64'(0));

      // fairness after reset: all four requesting for 8 cycles
      rst = 1'b0;
      cyc();
      rst = 1'b1;
      for (int i = 0; i < NREQ; i++) set_req(i, OW'(i), DW'(10 + i), DW'(100 * i));
      bus.req_vld = 4'b1111;
      for (int k = 0; k < 12; k++) begin
         if (k == 8) bus.req_vld = '0;
         #1;
         if (k < 8) chk("t2_rdy", 64'(bus.req_rdy), 64'(1 << (k % 4)));
         if (k >= 1 && k <= 8) begin
            chk("t2_alu_vld", 64'(bus.alu_vld), 64'(1));
            chk("t2_op0",     64'(bus.alu_op0), 64'(10 + (k - 1) % 4));
         end
         if (k == 9) chk("t2_alu_vld_off", 64'(bus.alu_vld), 64'(0));
         if (k >= 4) begin
            chk("t2_rsp_vld", 64'(bus.rsp_vld),    64'(1 << ((k - 4) % 4)));
            chk("t2_rsp_res", 64'(bus.rsp_result), 64'(10 + 101 * ((k - 4) % 4)));
         end
         cyc();
      end

      // wrap and skip: grant 2 first, then 1001 -> 3, 0, 3
      bus.req_vld = 4'b0100;
      #1; chk("t3_rdy2", 64'(bus.req_rdy), 64'(4'b0100));
      cyc(); bus.req_vld = 4'b1001;
      #1; chk("t3_rdy3a", 64'(bus.req_rdy), 64'(4'b1000));
      cyc(); #1; chk("t3_rdy0", 64'(bus.req_rdy), 64'(4'b0001));
      cyc(); #1; chk("t3_rdy3b", 64'(bus.req_rdy), 64'(4'b1000));
      bus.req_vld = '0;
      repeat (6) cyc();
      #1; chk("t3_err", 64'(bus.err), 64'(0));

      // stall: op from requester 2 in flight, ce=0 for 3 cycles
      set_req(2, 5'd1, 32'd1, 32'd2);
      set_req(0, 5'd2, 32'd4, 32'd4);
      bus.req_vld = 4'b0100;
      #1; chk("t4_rdy2", 64'(bus.req_rdy), 64'(4'b0100));
      cyc(); bus.req_vld = '0; #1;
      chk("t4_alu_vld", 64'(bus.alu_vld), 64'(1));
      chk("t4_op0",     64'(bus.alu_op0), 64'(1));
      cyc();
      ce = 1'b0;
      bus.req_vld = 4'b0001;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("t4_stall_rdy", 64'(bus.req_rdy), 64'(0));
         chk("t4_stall_rsp", 64'(bus.rsp_vld), 64'(0));
         chk("t4_stall_vld", 64'(bus.alu_vld), 64'(0));
         chk("t4_stall_op0", 64'(bus.alu_op0), 64'(1));
         cyc();
      end
      ce = 1'b1;
      #1;
      chk("t4_rdy0", 64'(bus.req_rdy), 64'(4'b0001));
      chk("t4_rsp_none", 64'(bus.rsp_vld), 64'(0));
      cyc(); bus.req_vld = '0; #1;
      chk("t4_res_vld", 64'(bus.alu_result_vld), 64'(1));
      chk("t4_rsp_late", 64'(bus.rsp_vld), 64'(0));
      chk("t4_op0_req0", 64'(bus.alu_op0), 64'(4));
      cyc(); #1;
      chk("t4_rsp2",     64'(bus.rsp_vld),    64'(4'b0100));
      chk("t4_rsp2_res", 64'(bus.rsp_result), 64'(3));
      cyc(); #1;
      chk("t4_rsp_gap", 64'(bus.rsp_vld), 64'(0));
      cyc(); #1;
      chk("t4_rsp0",     64'(bus.rsp_vld),    64'(4'b0001));
      chk("t4_rsp0_res", 64'(bus.rsp_result), 64'(8));
      cyc();

      // error: result_vld with an empty tag pipeline
      inj = 1'b1;
      cyc();
      inj = 1'b0;
      #1;
      chk("t5_err_set", 64'(bus.err),     64'(1));
      chk("t5_no_rsp",  64'(bus.rsp_vld), 64'(0));
      repeat (3) cyc();
      #1; chk("t5_err_sticky", 64'(bus.err), 64'(1));
      rst = 1'b0;
      cyc();
      rst = 1'b1;
      #1; chk("t5_err_clr", 64'(bus.err), 64'(0));

      // reset one cycle after accept discards the op
      set_req(3, 5'd4, 32'd20, 32'd22);
      bus.req_vld = 4'b1000;
      #1; chk("t6_rdy3", 64'(bus.req_rdy), 64'(4'b1000));
      cyc();
      bus.req_vld = '0;
      rst = 1'b0;
      #1;
      chk("t6_alu_vld", 64'(bus.alu_vld), 64'(1));
      cyc();
      rst = 1'b1;
      #1;
      chk("t6_alu_vld_clr", 64'(bus.alu_vld), 64'(0));
      for (int k = 0; k < 6; k++) begin
         cyc(); #1;
         chk("t6_no_rsp", 64'(bus.rsp_vld), 64'(0));
      end
      chk("t6_err", 64'(bus.err), 64'(0));

      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end
endmodule
